// File: rtl/dmem_store_buffer_pkg.sv
// Shared types for the data-memory store buffer: entry layout, default depth
// and the word-address compare used by load forwarding.
package dmem_sbuf_pkg;

    localparam int SBUF_DEPTH = 4;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
    } sbuf_entry_t;

    // Word granularity: byte offset bits are dropped before this compare
    function automatic logic word_match(input logic [29:0] a, input logic [29:0] b);
        return a == b;
    endfunction

endpackage

// File: rtl/dmem_store_buffer_if.sv
// Core Memory-stage port, backing-memory drain port and status flags.
// The buffer sits on the slave side; core and memory drive from the master side.
interface dmem_store_buffer_if;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic [31:0] MemRAddr;
    logic [31:0] MemRData;
    logic        MemValid;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemReady;
    logic        Full;
    logic        Empty;
    logic        Overflow;

    modport slave (
        input  MemWriteM, ALUOutM, WriteDataM, MemRData, MemReady,
        output ReadDataM, MemRAddr, MemValid, MemAddr, MemWData, Full, Empty, Overflow
    );

    modport master (
        output MemWriteM, ALUOutM, WriteDataM, MemRData, MemReady,
        input  ReadDataM, MemRAddr, MemValid, MemAddr, MemWData, Full, Empty, Overflow
    );
endinterface

// File: rtl/dmem_store_buffer_fifo.sv
// Circular store FIFO: entry storage plus head/tail/count bookkeeping.
// Exposes all entries and a head/count-derived valid vector for forwarding.
module sbuf_fifo
    import dmem_sbuf_pkg::*;
#(
    parameter  int DEPTH = SBUF_DEPTH,
    localparam int PTRW  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  sbuf_entry_t             wentry_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [PTRW-1:0]         head_o,
    output sbuf_entry_t [DEPTH-1:0] entries_o,
    output logic [DEPTH-1:0]        valid_o
);

    logic [PTRW-1:0]         head_q, head_d;
    logic [PTRW-1:0]         tail_q, tail_d;
    logic [PTRW:0]           count_q, count_d;
    sbuf_entry_t [DEPTH-1:0] mem_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) tail_d = tail_q + 1'b1;
        if (pop_i)  head_d = head_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left out of reset; validity comes from head/count
    always_ff @(posedge clk) begin
        if (push_i) mem_q[tail_q] <= wentry_i;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
        logic [PTRW-1:0] offs;
        assign offs       = PTRW'(i) - head_q;
        assign valid_o[i] = {1'b0, offs} < count_q;
    end

    assign full_o    = count_q == (PTRW+1)'(DEPTH);
    assign empty_o   = count_q == '0;
    assign head_o    = head_q;
    assign entries_o = mem_q;

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the core M-stage and data memory:
// handshake glue, sticky overflow flag and youngest-match load forwarding.
module dmem_store_buffer
    import dmem_sbuf_pkg::*;
#(
    parameter int DEPTH = SBUF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    dmem_store_buffer_if.slave bus
);

    localparam int PTRW = $clog2(DEPTH);

    logic                    push, pop, full, empty;
    logic [PTRW-1:0]         head;
    sbuf_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]        valid;
    sbuf_entry_t             wentry, head_e;
    logic                    overflow_q, overflow_d;
    logic [PTRW-1:0]         idx;
    logic [31:0]             fwd_data;

    assign pop    = bus.MemValid & bus.MemReady;
    // A full buffer still takes a store when the head drains in the same cycle
    assign push   = bus.MemWriteM & (~full | pop);
    assign wentry = '{waddr: bus.ALUOutM[31:2], data: bus.WriteDataM};

    sbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_i   (push),
        .pop_i    (pop),
        .wentry_i (wentry),
        .full_o   (full),
        .empty_o  (empty),
        .head_o   (head),
        .entries_o(entries),
        .valid_o  (valid)
    );

    assign overflow_d = overflow_q | (bus.MemWriteM & full & ~pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) overflow_q <= 1'b0;
        else       overflow_q <= overflow_d;
    end

    // Walk oldest to youngest so the last hit (nearest tail) wins
    always_comb begin
        fwd_data = bus.MemRData;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTRW'(k);
            if (valid[idx] && word_match(entries[idx].waddr, bus.ALUOutM[31:2]))
                fwd_data = entries[idx].data;
        end
    end

    assign head_e        = entries[head];
    assign bus.MemValid  = ~empty;
    assign bus.MemAddr   = {head_e.waddr, 2'b00};
    assign bus.MemWData  = head_e.data;
    assign bus.MemRAddr  = bus.ALUOutM;
    assign bus.ReadDataM = fwd_data;
    assign bus.Full      = full;
    assign bus.Empty     = empty;
    assign bus.Overflow  = overflow_q;

endmodule
